// File: rtl/imem_uart_loader.sv
// UART 8N1 program loader: a byte count followed by little-endian 32-bit words,
// each written to instruction memory through a single-cycle write port.
module imem_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        we,
  output logic [7:0]  waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] BitLast  = TimerW'(CLKS_PER_BIT - 1);
  localparam logic [TimerW-1:0] HalfLast = TimerW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RIdle, RStart, RData, RStop} rx_state_e;
  typedef enum logic [1:0] {LIdle, LLoad, LWrite} ld_state_e;

  logic              rx_meta_q, rx_sync_q;
  rx_state_e         rstate_q, rstate_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_bad_q, frame_bad_d;
  logic              frame_err_q;

  ld_state_e         lstate_q, lstate_d;
  logic [7:0]        count_q, count_d;
  logic [7:0]        word_idx_q, word_idx_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        word_next;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate_q     <= RIdle;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_bad_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rstate_q     <= rstate_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      byte_valid_q <= byte_valid_d;
      frame_bad_q  <= frame_bad_d;
      frame_err_q  <= frame_err_q | frame_bad_q;
    end
  end

  always_comb begin
    rstate_d     = rstate_q;
    timer_d      = timer_q + 1'b1;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    byte_valid_d = 1'b0;
    frame_bad_d  = 1'b0;
    unique case (rstate_q)
      RIdle: begin
        timer_d = '0;
        if (!rx_sync_q) rstate_d = RStart;
      end
      RStart: begin
        // Mid-start-bit recheck rejects short low glitches.
        if (timer_q == HalfLast) begin
          timer_d   = '0;
          bit_idx_d = '0;
          rstate_d  = rx_sync_q ? RIdle : RData;
        end
      end
      RData: begin
        if (timer_q == BitLast) begin
          timer_d   = '0;
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rstate_d = RStop;
        end
      end
      RStop: begin
        if (timer_q == BitLast) begin
          timer_d      = '0;
          rstate_d     = RIdle;
          byte_valid_d = rx_sync_q;
          frame_bad_d  = !rx_sync_q;
        end
      end
      default: rstate_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lstate_q   <= LIdle;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      lstate_q   <= lstate_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign word_next = word_idx_q + 1'b1;

  always_comb begin
    lstate_d   = lstate_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    unique case (lstate_q)
      LIdle: begin
        if (byte_valid_q) begin
          if (shreg_q == 8'd0) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            count_d    = shreg_q;
            word_idx_d = '0;
            byte_idx_d = '0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            lstate_d   = LLoad;
          end
        end
      end
      LLoad: begin
        if (byte_valid_q) begin
          byte_idx_d = byte_idx_q + 1'b1;
          unique case (byte_idx_q)
            2'd0: asm_d[7:0]   = shreg_q;
            2'd1: asm_d[15:8]  = shreg_q;
            2'd2: asm_d[23:16] = shreg_q;
            default: begin
              // Output registers change only on a complete word.
              wdata_d  = {shreg_q, asm_q};
              waddr_d  = word_idx_q;
              lstate_d = LWrite;
            end
          endcase
        end
      end
      LWrite: begin
        word_idx_d = word_next;
        if (word_next == count_q) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          lstate_d = LIdle;
        end else begin
          lstate_d = LLoad;
        end
      end
      default: lstate_d = LIdle;
    endcase
    if (frame_bad_q) begin
      lstate_d = LIdle;
      busy_d   = 1'b0;
    end
  end

  assign we        = (lstate_q == LWrite);
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: table of load transactions plus
// hand-written frame-error, glitch and mid-load reset sequences.
module tb_imem_uart_loader;

  localparam int Bit = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        busy, done, frame_err;

  imem_uart_loader #(.CLKS_PER_BIT(Bit)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Write-port monitor: only this block writes these variables.
  logic [7:0]  cap_addr[$];
  logic [31:0] cap_data[$];
  int   we_total = 0;
  int   we_double = 0;
  int   busy_cycles = 0;
  logic prev_we = 1'b0;
  logic busy_at_we = 1'b0, done_at_we = 1'b0;
  logic post_busy = 1'b0, post_done = 1'b0;

  always @(negedge clk) begin
    if (prev_we) begin
      post_busy = busy;
      post_done = done;
    end
    if (we) begin
      cap_addr.push_back(waddr);
      cap_data.push_back(wdata);
      we_total++;
      busy_at_we = busy;
      done_at_we = done;
      if (prev_we) we_double++;
    end
    if (busy) busy_cycles++;
    prev_we = we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(Bit);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(Bit);
    end
    rx = stop;
    idle(Bit);
    rx = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_waddr"}, 32'(waddr), 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  task automatic load_one(input logic [31:0] word, input string tag);
    int base;
    base = we_total;
    send_byte(8'h01, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(word[8*k +: 8], 1'b1);
    idle(20);
    check({tag, "_we_count"}, 32'(we_total - base), 32'd1);
    if (cap_data.size() > base) begin
      check({tag, "_waddr"}, 32'(cap_addr[base]), 32'd0);
      check({tag, "_wdata"}, cap_data[base], word);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  hdr;
    int          nb;
    logic [63:0] bytes;  // byte k at [8k +: 8], sent in order k = 0, 1, ...
    int          nw;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base, bc0;
    vecs[0] = '{8'h02, 8, 64'h00A00593_00500513, 2, 32'h00500513, 32'h00A00593};
    vecs[1] = '{8'h00, 0, 64'h0, 0, 32'h0, 32'h0};
    vecs[2] = '{8'h01, 4, 64'h00000000_DEADBEEF, 1, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{8'h01, 4, 64'h00000000_04030201, 1, 32'h04030201, 32'h0};
    vecs[4] = '{8'h02, 8, 64'h12345678_800000FF, 2, 32'h800000FF, 32'h12345678};

    rx = 1'b1;
    reset = 1'b1;
    #1;
    check_all_zero("rst");
    idle(5);
    reset = 1'b0;

    base = we_total;
    bc0 = busy_cycles;
    idle(1000);
    check_all_zero("idle");
    check("idle_we_count", 32'(we_total - base), 32'd0);
    check("idle_busy_cycles", 32'(busy_cycles - bc0), 32'd0);

    for (int v = 0; v < 5; v++) begin
      base = we_total;
      bc0 = busy_cycles;
      send_byte(vecs[v].hdr, 1'b1);
      if (vecs[v].nw > 0) check($sformatf("v%0d_busy_after_hdr", v), 32'(busy), 32'd1);
      for (int k = 0; k < vecs[v].nb; k++) send_byte(vecs[v].bytes[8*k +: 8], 1'b1);
      idle(20);
      check($sformatf("v%0d_we_count", v), 32'(we_total - base), 32'(vecs[v].nw));
      for (int w = 0; w < vecs[v].nw; w++) begin
        if (cap_data.size() > base + w) begin
          check($sformatf("v%0d_waddr%0d", v, w), 32'(cap_addr[base+w]), 32'(w));
          check($sformatf("v%0d_wdata%0d", v, w), cap_data[base+w],
                (w == 0) ? vecs[v].d0 : vecs[v].d1);
        end
      end
      check($sformatf("v%0d_done", v), 32'(done), 32'd1);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      if (vecs[v].nw > 0) begin
        check($sformatf("v%0d_busy_at_we", v), 32'(busy_at_we), 32'd1);
        check($sformatf("v%0d_done_at_we", v), 32'(done_at_we), 32'd0);
        check($sformatf("v%0d_busy_after_we", v), 32'(post_busy), 32'd0);
        check($sformatf("v%0d_done_after_we", v), 32'(post_done), 32'd1);
      end else begin
        check($sformatf("v%0d_busy_cycles", v), 32'(busy_cycles - bc0), 32'd0);
      end
    end

    // Bad stop bit in the third byte of a one-word load.
    base = we_total;
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    idle(40);
    check("ferr_frame_err", 32'(frame_err), 32'd1);
    check("ferr_busy", 32'(busy), 32'd0);
    check("ferr_done", 32'(done), 32'd0);
    check("ferr_we_count", 32'(we_total - base), 32'd0);
    load_one(32'h00001337, "ferr_reload");
    check("ferr_sticky", 32'(frame_err), 32'd1);

    // One-cycle low glitch while idle.
    base = we_total;
    bc0 = busy_cycles;
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(40);
    check("glitch_we_count", 32'(we_total - base), 32'd0);
    check("glitch_busy_cycles", 32'(busy_cycles - bc0), 32'd0);
    check("glitch_done", 32'(done), 32'd1);
    check("glitch_wdata", wdata, 32'h00001337);
    load_one(32'hA5A55A5A, "glitch_reload");

    // Reset during the third byte of a load.
    base = we_total;
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    rx = 1'b0;
    idle(Bit * 4);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    rx = 1'b1;
    idle(20);
    check("midrst_we_count", 32'(we_total - base), 32'd0);
    reset = 1'b0;
    idle(40);
    check_all_zero("midrst_post");
    check("midrst_post_we_count", 32'(we_total - base), 32'd0);
    load_one(32'hCAFED00D, "midrst_reload");

    check("we_single_cycle", 32'(we_double), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Serial program loader that writes the instruction memory from a host over UART (8N1), the write-side counterpart of the CPU's instruction fetch path. It receives a one-byte word count followed by little-endian 32-bit instruction words, then presents each word on a single-cycle write port (`we`/`waddr`/`wdata`) to instruction memory. It holds the CPU through `busy` while loading and flags completion and framing errors for the top level.

## Interface
- `CLKS_PER_BIT`, 10416, `clk` cycles per UART bit (100 MHz / 9600 baud); minimum 8.
- `clk` in 1: system clock (undivided board clock).
- `reset` in 1: asynchronous, active-high.
- `rx` in 1: UART receive line, idle high, asynchronous to `clk`.
- `we` out 1: instruction-memory write strobe, one-cycle pulse per word.
- `waddr` out 8: word address for the current write.
- `wdata` out 32: instruction word for the current write.
- `busy` out 1: high from header reception until the last word is written; CPU must not advance while high.
- `done` out 1: high after a complete load; cleared by the next header byte.
- `frame_err` out 1: sticky; set on any bad stop bit; cleared only by reset.

## Operation
- Input sync: `rx` passes through a 2-FF synchronizer, reset to 1. All logic uses the synchronized value.
- Bit receiver states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: a synchronized `rx` of 0 enters R_START and clears the bit timer.
  - R_START: at timer = CLKS_PER_BIT/2 − 1, if `rx` is 0, go to R_DATA and restart the timer. If `rx` is 1, treat it as a glitch and return to R_IDLE.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register.
  - R_STOP: sample once after CLKS_PER_BIT. A 1 emits an internal one-cycle `byte_valid`. A 0 sets `frame_err`, emits no byte, and forces the loader to L_IDLE. Then go to R_IDLE.
- Loader states: L_IDLE, L_LOAD, L_WRITE.
  - L_IDLE: the next `byte_valid` is the header N (word count).
    - N = 0: no words; `done` = 1, `busy` = 0, remain in L_IDLE.
    - Otherwise: latch N, clear the word index and byte index, set `busy` = 1, clear `done`, go to L_LOAD.
  - L_LOAD: each `byte_valid` stores the byte into lane `byte_idx` (byte 0 → `wdata[7:0]` … byte 3 → `wdata[31:24]`) and increments `byte_idx` (2 bits). On the 4th byte, go to L_WRITE.
  - L_WRITE: one cycle with `we` = 1, `waddr` = word index, `wdata` = assembled word. Then increment the word index.
    - If the incremented index equals N: `busy` = 0, `done` = 1, go to L_IDLE.
    - Otherwise return to L_LOAD.
- Addresses run 0 … N−1 (N ≤ 255). No wrap occurs; address 255 is never written.
- `wdata` and `waddr` hold their last values outside L_WRITE. Consumers use them only when `we` = 1.
- Frame error mid-load: `busy` drops, `done` stays 0, words already written remain in memory, and the partial word is discarded.
- A new header after `done` starts a fresh load at address 0.

## Timing
- Reset values: `we` = 0, `waddr` = 0, `wdata` = 0, `busy` = 0, `done` = 0, `frame_err` = 0. Receiver is in R_IDLE, loader in L_IDLE.
- Reset asserted mid-byte or mid-load aborts immediately. No write strobe is issued during or after reset.
- Falling edge on `rx` to first internal start detect: 2 cycles (synchronizer).
- `byte_valid` occurs in the cycle after the stop-bit sample.
- `we` asserts in the cycle after the 4th byte's `byte_valid` and lasts exactly 1 cycle.
- `busy` falls and `done` rises in the cycle after the last `we`.
- `busy` rises in the cycle after the header's `byte_valid`.
- Back-to-back bytes (stop bit immediately followed by a start bit) are received with no loss. L_WRITE (1 cycle) always completes before the next start bit is detected.

## Test plan
Bench parameter: CLKS_PER_BIT = 16.
- Reset then idle line → all outputs 0 for 1000 cycles, `we` never pulses.
- Send header 0x02, then bytes 13 05 50 00 93 05 A0 00.
  - `we` pulses twice: (`waddr` 0, `wdata` 0x00500513), then (`waddr` 1, `wdata` 0x00A00593).
  - `busy` is high in between and falls with `done` rising in the cycle after the second `we`.
- Header 0x00 → `done` = 1 after the byte; `busy` never rises; no `we`.
- Header 0x01, 2 good bytes, then a byte with stop bit 0.
  - `frame_err` = 1 and `busy` = 0; no `we`; `done` = 0.
  - A following valid load of 1 word writes address 0 correctly.
- 1-cycle low glitch on `rx` while idle → no byte, no state change.
- Assert `reset` during the 3rd data byte of a load.
  - All outputs return to 0 asynchronously; no `we`.
  - After release, a full 1-word load succeeds.
